// File: rtl/cache_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_rd_arbiter_pkg
// Purpose : Constants shared by the cache refill read arbiter, its
//           sub-module and its testbench.
// Contents: read request type codes, one-hot FSM state encodings and
//           the owner encoding (which cache currently holds the grant).
// ---------------------------------------------------------------------------
package cache_rd_arbiter_pkg;

  // Read request types carried on x_rd_type / rd_type
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  // One-hot FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'b001;
  localparam logic [2:0] ST_ISSUE    = 3'b010;
  localparam logic [2:0] ST_WAIT_RET = 3'b100;

  // Owner / requester index. Index 0 is the instruction cache and index 1
  // is the data cache, matching the bit positions of the arbiter grant.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// cache_rd_arbiter_rr_arb2
// Purpose : Two-input combinational arbiter with a priority pointer.
//           With a single request active that request wins; with both
//           active the requester selected by i_ptr wins.
// Ports   :
//   i_req   [1:0] in   request vector (bit 0 = inst, bit 1 = data)
//   i_ptr         in   index of the requester that wins a tie
//   o_grant [1:0] out  one-hot grant, all zero when no request
// ---------------------------------------------------------------------------
module cache_rd_arbiter_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      // A requester wins when it asks and either the other side is quiet
      // or the pointer favours it.
      assign o_grant[gi] = i_req[gi] &
                           (~i_req[1 - gi] | (i_ptr == 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/cache_rd_arbiter.sv
// ---------------------------------------------------------------------------
// cache_rd_arbiter
// Purpose : Shares the single cache-refill read port of the AXI bridge
//           between the instruction cache and the data cache. One request
//           is granted at a time, forwarded downstream, and the returned
//           beats are steered back to the owner until the last beat. A data
//           read that hits the line of a still-outstanding data write is held
//           off until the write response arrives.
// Ports   :
//   clk, resetn                  clock, synchronous active-low reset
//   i_rd_*  / i_ret_*            instruction cache request / return
//   d_rd_*  / d_ret_*            data cache request / return
//   d_wr_req, d_wr_addr,
//   d_wr_rdy, wr_done            snooped write handshake for hazard tracking
//   rd_req, rd_type, rd_addr,
//   rd_rdy                       downstream read request channel
//   ret_valid, ret_last,
//   ret_data                     downstream read return channel
// ---------------------------------------------------------------------------
module cache_rd_arbiter
  import cache_rd_arbiter_pkg::*;
#(
  parameter int RR_EN      = 1,
  parameter int ADDR_W     = 32,
  parameter int LINE_OFF_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction cache
  input  logic              i_rd_req,
  input  logic [2:0]        i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_last,
  output logic [31:0]       i_ret_data,
  // data cache
  input  logic              d_rd_req,
  input  logic [2:0]        d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_last,
  output logic [31:0]       d_ret_data,
  // snooped data-cache write
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic              d_wr_rdy,
  input  logic              wr_done,
  // downstream read port
  output logic              rd_req,
  output logic [2:0]        rd_type,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [31:0]       ret_data
);

  localparam int LINE_W = ADDR_W - LINE_OFF_W;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic              r_owner;
  logic              r_rr_ptr;
  logic              r_wr_pend;
  logic [LINE_W-1:0] r_wr_line;

  logic [2:0]        w_state_next;
  logic              w_owner_next;
  logic              w_rr_ptr_next;

  // -------------------------------------------------------------------------
  // Decode helpers
  // -------------------------------------------------------------------------
  logic w_st_idle;
  logic w_st_issue;
  logic w_st_wait;
  logic w_own_inst;
  logic w_own_data;
  logic w_own_req;
  logic w_accept;
  logic w_abort;
  logic w_ret_end;

  assign w_st_idle  = (r_state == ST_IDLE);
  assign w_st_issue = (r_state == ST_ISSUE);
  assign w_st_wait  = (r_state == ST_WAIT_RET);
  assign w_own_inst = (r_owner == OWNER_INST);
  assign w_own_data = (r_owner == OWNER_DATA);

  // The owner's request line must stay high through ISSUE; if it drops
  // the grant is abandoned and a coincident rd_rdy is not forwarded.
  assign w_own_req = w_own_data ? d_rd_req : i_rd_req;
  assign w_accept  = w_st_issue & w_own_req & rd_rdy;
  assign w_abort   = w_st_issue & ~w_own_req;
  assign w_ret_end = w_st_wait & ret_valid & ret_last;

  // -------------------------------------------------------------------------
  // Read-after-write hazard: a data read may not overtake an outstanding
  // write to the same line, otherwise it could refill stale data.
  // -------------------------------------------------------------------------
  logic w_wr_accept;
  logic w_rd_hazard;
  logic w_unused_wr_off;

  assign w_wr_accept     = d_wr_req & d_wr_rdy;
  assign w_rd_hazard     = r_wr_pend &&
                           (d_rd_addr[ADDR_W-1:LINE_OFF_W] == r_wr_line);
  // Offset bits of the write address do not take part in the line compare.
  assign w_unused_wr_off = ^d_wr_addr[LINE_OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_pend <= 1'b0;
      r_wr_line <= '0;
    end else if (w_wr_accept) begin
      // A newly accepted write takes precedence over a same-cycle wr_done:
      // the new write is still outstanding.
      r_wr_pend <= 1'b1;
      r_wr_line <= d_wr_addr[ADDR_W-1:LINE_OFF_W];
    end else if (wr_done) begin
      r_wr_pend <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [1:0] w_elig;
  logic [1:0] w_grant;
  logic       w_arb_ptr;

  assign w_elig[OWNER_INST] = i_rd_req;
  assign w_elig[OWNER_DATA] = d_rd_req & ~w_rd_hazard;

  // Fixed-priority mode simply pins the tie-break pointer to the data side.
  assign w_arb_ptr = (RR_EN != 0) ? r_rr_ptr : OWNER_DATA;

  cache_rd_arbiter_rr_arb2 u_rr_arb2 (
    .i_req   (w_elig),
    .i_ptr   (w_arb_ptr),
    .o_grant (w_grant)
  );

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_rr_ptr_next = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_state_next = ST_ISSUE;
          w_owner_next = w_grant[OWNER_DATA];
        end
      end
      ST_ISSUE: begin
        if (w_accept) begin
          w_state_next = ST_WAIT_RET;
        end else if (w_abort) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_RET: begin
        if (w_ret_end) begin
          w_state_next = ST_IDLE;
          // Hand the tie-break to the side that was just not served.
          if (RR_EN != 0) begin
            w_rr_ptr_next = ~r_owner;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWNER_INST;
      r_rr_ptr <= OWNER_INST;
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Downstream request mux (only live in ISSUE; IDLE is the arbitration
  // cycle and drives nothing).
  // -------------------------------------------------------------------------
  assign rd_req  = w_st_issue & w_own_req;
  assign rd_type = w_st_issue ? (w_own_data ? d_rd_type : i_rd_type) : 3'b000;
  assign rd_addr = w_st_issue ? (w_own_data ? d_rd_addr : i_rd_addr) : '0;

  assign i_rd_rdy = w_accept & w_own_inst;
  assign d_rd_rdy = w_accept & w_own_data;

  // -------------------------------------------------------------------------
  // Return steering: beats outside WAIT_RET are stray and dropped.
  // -------------------------------------------------------------------------
  logic w_ret_to_i;
  logic w_ret_to_d;

  assign w_ret_to_i = w_st_wait & w_own_inst;
  assign w_ret_to_d = w_st_wait & w_own_data;

  assign i_ret_valid = w_ret_to_i & ret_valid;
  assign i_ret_last  = w_ret_to_i & ret_last;
  assign i_ret_data  = w_ret_to_i ? ret_data : 32'h0;

  assign d_ret_valid = w_ret_to_d & ret_valid;
  assign d_ret_last  = w_ret_to_d & ret_last;
  assign d_ret_data  = w_ret_to_d ? ret_data : 32'h0;

  // w_st_idle is kept for readability of the state decode set.
  logic w_unused_idle;
  assign w_unused_idle = w_st_idle;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_rd_arbiter
// Directed testbench for cache_rd_arbiter. Two instances share all inputs:
// dut (round-robin) and dut_fp (fixed priority, data over inst).
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// 1 time unit later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_cache_rd_arbiter;
  import cache_rd_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_rd_req;
  logic [2:0]  i_rd_type;
  logic [31:0] i_rd_addr;
  logic        d_rd_req;
  logic [2:0]  d_rd_type;
  logic [31:0] d_rd_addr;
  logic        d_wr_req;
  logic [31:0] d_wr_addr;
  logic        d_wr_rdy;
  logic        wr_done;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  // round-robin instance outputs
  logic        i_rd_rdy, i_ret_valid, i_ret_last;
  logic [31:0] i_ret_data;
  logic        d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0] d_ret_data;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;

  // fixed-priority instance outputs
  logic        f_i_rd_rdy, f_i_ret_valid, f_i_ret_last;
  logic [31:0] f_i_ret_data;
  logic        f_d_rd_rdy, f_d_ret_valid, f_d_ret_last;
  logic [31:0] f_d_ret_data;
  logic        f_rd_req;
  logic [2:0]  f_rd_type;
  logic [31:0] f_rd_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_rd_arbiter #(.RR_EN(1), .ADDR_W(32), .LINE_OFF_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
    .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
    .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_rdy(d_wr_rdy),
    .wr_done(wr_done),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  cache_rd_arbiter #(.RR_EN(0), .ADDR_W(32), .LINE_OFF_W(4)) dut_fp (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
    .i_rd_rdy(f_i_rd_rdy), .i_ret_valid(f_i_ret_valid),
    .i_ret_last(f_i_ret_last), .i_ret_data(f_i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
    .d_rd_rdy(f_d_rd_rdy), .d_ret_valid(f_d_ret_valid),
    .d_ret_last(f_d_ret_last), .d_ret_data(f_d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_rdy(d_wr_rdy),
    .wr_done(wr_done),
    .rd_req(f_rd_req), .rd_type(f_rd_type), .rd_addr(f_rd_addr),
    .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_rd_req = 0; i_rd_type = 3'b000; i_rd_addr = 32'h0;
    d_rd_req = 0; d_rd_type = 3'b000; d_rd_addr = 32'h0;
    d_wr_req = 0; d_wr_addr = 32'h0; d_wr_rdy = 0; wr_done = 0;
    rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 32'h0;
  endtask

  // Leaves the bench in the cycle right after a reset edge, resetn released.
  task automatic reset_dut();
    resetn = 0;
    clear_inputs();
    cyc();
    cyc();
    resetn = 1;
  endtask

  task automatic test_reset();
    logic [109:0] all_out;
    logic [109:0] f_all_out;
    reset_dut();
    #1;
    all_out = {i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data, d_rd_rdy,
               d_ret_valid, d_ret_last, d_ret_data, rd_req, rd_type, rd_addr};
    f_all_out = {f_i_rd_rdy, f_i_ret_valid, f_i_ret_last, f_i_ret_data,
                 f_d_rd_rdy, f_d_ret_valid, f_d_ret_last, f_d_ret_data,
                 f_rd_req, f_rd_type, f_rd_addr};
    checks++; if (all_out !== '0) begin failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out); end
    checks++; if (f_all_out !== '0) begin failures++;
      $display("FAIL reset_outputs_fp got=%h exp=0", f_all_out); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_single_line();
    reset_dut();
    i_rd_req = 1; i_rd_addr = 32'h1c000040; i_rd_type = RD_TYPE_LINE;
    #1;
    checks++; if (rd_req !== 1'b0) begin failures++;
      $display("FAIL t1_idle_rd_req got=%0h exp=0", rd_req); end
    cyc(); #1;
    checks++; if (rd_req !== 1'b1) begin failures++;
      $display("FAIL t1_issue_rd_req got=%0h exp=1", rd_req); end
    checks++; if (rd_addr !== 32'h1c000040) begin failures++;
      $display("FAIL t1_rd_addr got=%h exp=1c000040", rd_addr); end
    checks++; if (rd_type !== 3'b100) begin failures++;
      $display("FAIL t1_rd_type got=%b exp=100", rd_type); end
    checks++; if (i_rd_rdy !== 1'b0) begin failures++;
      $display("FAIL t1_rdy_early got=%0h exp=0", i_rd_rdy); end
    cyc();
    rd_rdy = 1; #1;
    checks++; if ({i_rd_rdy, d_rd_rdy} !== 2'b10) begin failures++;
      $display("FAIL t1_rdy_pulse got=%b exp=10", {i_rd_rdy, d_rd_rdy}); end
    cyc();
    rd_rdy = 0; i_rd_req = 0;
    for (int b = 0; b < 4; b++) begin
      ret_valid = 1; ret_data = 32'hA0 + 32'(b); ret_last = (b == 3); #1;
      checks++;
      if ({i_ret_valid, i_ret_last, i_ret_data, d_ret_valid} !==
          {1'b1, (b == 3), 32'hA0 + 32'(b), 1'b0}) begin
        failures++;
        $display("FAIL t1_beat%0d got=%b/%b/%h/%b exp=1/%b/%h/0", b,
                 i_ret_valid, i_ret_last, i_ret_data, d_ret_valid,
                 (b == 3), 32'hA0 + 32'(b));
      end
      cyc();
    end
    ret_valid = 0; ret_last = 0; #1;
    checks++; if ({rd_req, i_ret_valid} !== 2'b00) begin failures++;
      $display("FAIL t1_after_last got=%b exp=00", {rd_req, i_ret_valid}); end
    $display("test_single_line: inst line read 0x1c000040, 4 beats");
  endtask

  // Both requests held high throughout so each instance re-arbitrates.
  task automatic test_priority();
    reset_dut();
    i_rd_req = 1; i_rd_addr = 32'h00000100; i_rd_type = RD_TYPE_LINE;
    d_rd_req = 1; d_rd_addr = 32'h00000200; d_rd_type = RD_TYPE_LINE;
    for (int r = 0; r < 2; r++) begin
      cyc();
      rd_rdy = 1; #1;
      checks++;
      if (rd_addr !== ((r == 0) ? 32'h100 : 32'h200)) begin failures++;
        $display("FAIL t2_rr_round%0d got=%h exp=%h", r, rd_addr,
                 (r == 0) ? 32'h100 : 32'h200); end
      checks++;
      if ({i_rd_rdy, d_rd_rdy} !== ((r == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL t2_rr_rdy%0d got=%b exp=%b", r, {i_rd_rdy, d_rd_rdy},
                 (r == 0) ? 2'b10 : 2'b01); end
      checks++;
      if (f_rd_addr !== 32'h200) begin failures++;
        $display("FAIL t2_fp_round%0d got=%h exp=200", r, f_rd_addr); end
      checks++;
      if ({f_i_rd_rdy, f_d_rd_rdy} !== 2'b01) begin failures++;
        $display("FAIL t2_fp_rdy%0d got=%b exp=01", r,
                 {f_i_rd_rdy, f_d_rd_rdy}); end
      cyc();
      rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'h55 + 32'(r);
      cyc();
      ret_valid = 0; ret_last = 0;
      $display("test_priority: round %0d, rr=%s fp=data", r,
               (r == 0) ? "inst" : "data");
    end
    i_rd_req = 0; d_rd_req = 0;
  endtask

  task automatic test_raw_hazard();
    reset_dut();
    d_wr_req = 1; d_wr_rdy = 1; d_wr_addr = 32'h00001230;
    cyc();
    d_wr_req = 0; d_wr_rdy = 0;
    // different line: not blocked
    d_rd_req = 1; d_rd_addr = 32'h00001240; d_rd_type = RD_TYPE_LINE;
    cyc(); rd_rdy = 1; #1;
    checks++; if ({rd_req, rd_addr} !== {1'b1, 32'h00001240}) begin failures++;
      $display("FAIL t3_other_line got=%b/%h exp=1/00001240", rd_req, rd_addr); end
    cyc();
    rd_rdy = 0; d_rd_req = 0; ret_valid = 1; ret_last = 1;
    cyc();
    ret_valid = 0; ret_last = 0;
    // same line: blocked while the write is pending
    d_rd_req = 1; d_rd_addr = 32'h00001238;
    cyc(); #1;
    checks++; if (rd_req !== 1'b0) begin failures++;
      $display("FAIL t3_blocked got=%0h exp=0", rd_req); end
    wr_done = 1;
    cyc();
    wr_done = 0; #1;
    checks++; if (rd_req !== 1'b0) begin failures++;
      $display("FAIL t3_idle_after_done got=%0h exp=0", rd_req); end
    cyc(); #1;
    checks++; if ({rd_req, rd_addr} !== {1'b1, 32'h00001238}) begin failures++;
      $display("FAIL t3_granted got=%b/%h exp=1/00001238", rd_req, rd_addr); end
    d_rd_req = 0;
    cyc();
    $display("test_raw_hazard: write 0x1230, reads 0x1240 and 0x1238");
  endtask

  task automatic test_abort();
    reset_dut();
    i_rd_req = 1; i_rd_addr = 32'h00000300; i_rd_type = RD_TYPE_LINE;
    cyc();
    i_rd_req = 0; d_rd_req = 1; d_rd_addr = 32'h00000400;
    d_rd_type = RD_TYPE_LINE; #1;
    checks++; if ({rd_req, i_rd_rdy} !== 2'b00) begin failures++;
      $display("FAIL t4_abort got=%b exp=00", {rd_req, i_rd_rdy}); end
    cyc();
    ret_valid = 1; #1;
    checks++; if ({i_ret_valid, d_ret_valid, rd_req} !== 3'b000) begin
      failures++;
      $display("FAIL t4_idle_again got=%b exp=000",
               {i_ret_valid, d_ret_valid, rd_req}); end
    cyc();
    ret_valid = 0; rd_rdy = 1; #1;
    checks++;
    if ({rd_req, rd_addr, d_rd_rdy, i_rd_rdy} !== {1'b1, 32'h400, 2'b10}) begin
      failures++;
      $display("FAIL t4_data_next got=%b/%h/%b/%b exp=1/00000400/1/0",
               rd_req, rd_addr, d_rd_rdy, i_rd_rdy); end
    cyc();
    rd_rdy = 0; d_rd_req = 0;
    $display("test_abort: inst dropped in ISSUE, data granted next");
  endtask

  task automatic test_word_read();
    reset_dut();
    d_rd_req = 1; d_rd_addr = 32'h1faf0004; d_rd_type = RD_TYPE_WORD;
    cyc();
    rd_rdy = 1; #1;
    checks++; if ({d_rd_rdy, rd_type} !== {1'b1, 3'b010}) begin failures++;
      $display("FAIL t5_issue got=%b/%b exp=1/010", d_rd_rdy, rd_type); end
    cyc();
    rd_rdy = 0; d_rd_req = 0;
    ret_valid = 1; ret_last = 1; ret_data = 32'hdeadbeef; #1;
    checks++;
    if ({d_ret_valid, d_ret_last, d_ret_data, i_ret_valid} !==
        {2'b11, 32'hdeadbeef, 1'b0}) begin
      failures++;
      $display("FAIL t5_beat got=%b/%b/%h/%b exp=1/1/deadbeef/0",
               d_ret_valid, d_ret_last, d_ret_data, i_ret_valid); end
    cyc();
    ret_data = 32'h12345678; #1;
    checks++; if ({d_ret_valid, d_ret_last} !== 2'b00) begin failures++;
      $display("FAIL t5_idle_next got=%b exp=00", {d_ret_valid, d_ret_last}); end
    ret_valid = 0; ret_last = 0;
    $display("test_word_read: data word read 0x1faf0004");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    i_rd_req = 1; i_rd_addr = 32'h00000500; i_rd_type = RD_TYPE_LINE;
    cyc();
    rd_rdy = 1;
    cyc();
    rd_rdy = 0; i_rd_req = 0;
    for (int b = 0; b < 2; b++) begin
      ret_valid = 1; ret_data = 32'hB0 + 32'(b); #1;
      checks++; if (i_ret_data !== 32'hB0 + 32'(b)) begin failures++;
        $display("FAIL t6_beat%0d got=%h exp=%h", b, i_ret_data,
                 32'hB0 + 32'(b)); end
      cyc();
    end
    ret_data = 32'hB2; resetn = 0;
    cyc();
    resetn = 1; ret_valid = 1; ret_data = 32'hB3;
    i_rd_req = 1; i_rd_addr = 32'h00000600; #1;
    checks++;
    if ({i_ret_valid, i_ret_data, d_ret_valid, rd_req, i_rd_rdy} !== '0) begin
      failures++;
      $display("FAIL t6_after_reset got=%b/%h/%b/%b/%b exp=0", i_ret_valid,
               i_ret_data, d_ret_valid, rd_req, i_rd_rdy); end
    cyc();
    ret_valid = 0; rd_rdy = 1; #1;
    checks++;
    if ({rd_req, rd_addr, i_rd_rdy} !== {1'b1, 32'h600, 1'b1}) begin
      failures++;
      $display("FAIL t6_regrant got=%b/%h/%b exp=1/00000600/1", rd_req,
               rd_addr, i_rd_rdy); end
    cyc();
    rd_rdy = 0; i_rd_req = 0; ret_valid = 1; ret_last = 1;
    cyc();
    ret_valid = 0; ret_last = 0;
    $display("test_reset_mid: reset during WAIT_RET, regrant 0x600");
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_single_line();
    test_priority();
    test_raw_hazard();
    test_abort();
    test_word_read();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_rd_arbiter.md
Name: cache_rd_arbiter

Overview:
Shares the single cache-refill read port of the AXI bridge between the instruction cache and the data cache. Both caches use the same request protocol: req/type/addr/rdy, then ret_valid/ret_last/ret_data. The block grants one requester at a time, forwards its request downstream and steers the returned beats back to the owner until ret_last. It also blocks a data-cache read whose line matches a data-cache write that is still in flight.

Parameters:
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority with data over inst
- ADDR_W, 32, request address width
- LINE_OFF_W, 4, line offset bits ignored in the read-after-write compare (16-byte lines)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- i_rd_req  in  1  inst-cache read request, held until i_rd_rdy
- i_rd_type  in  3  3'b100 = line, 3'b010 = word
- i_rd_addr  in  ADDR_W  inst-cache read address
- i_rd_rdy  out  1  inst request accepted
- i_ret_valid  out  1  return beat valid for inst cache
- i_ret_last  out  1  last return beat for inst cache
- i_ret_data  out  32  return data for inst cache
- d_rd_req, d_rd_type, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data  same as i_* for the data cache
- d_wr_req  in  1  data-cache write request, snooped only
- d_wr_addr  in  ADDR_W  data-cache write address, snooped only
- d_wr_rdy  in  1  bridge accepted the write, snooped only
- wr_done  in  1  bridge write response (B channel) has completed
- rd_req  out  1  downstream read request
- rd_type  out  3  downstream read type
- rd_addr  out  ADDR_W  downstream read address
- rd_rdy  in  1  downstream accepted the request
- ret_valid  in  1  downstream return beat valid
- ret_last  in  1  downstream last return beat
- ret_data  in  32  downstream return data

Behaviour:
- Reset (resetn == 0 at a clk edge):
  - State goes to IDLE; owner, rr_ptr (points to inst), wr_pend and wr_line are cleared.
  - All outputs are 0 at reset and whenever not driven as described below.
- State machine: IDLE, ISSUE, WAIT_RET, one-hot encoded. At most one read is outstanding.
- IDLE:
  - Eligible requesters: i_rd_req, and d_rd_req && !(wr_pend && d_rd_addr[ADDR_W-1:LINE_OFF_W] == wr_line).
  - Two eligible with RR_EN=1: rr_ptr picks the winner. With RR_EN=0: data wins.
  - One eligible: it wins.
  - Winner is latched in owner; next state is ISSUE.
  - No downstream or requester output is asserted in IDLE (1-cycle arbitration latency).
- ISSUE:
  - rd_req = owner's req; rd_type and rd_addr are muxed combinationally from the owner.
  - owner's x_rd_rdy = rd_rdy, combinational, in the same cycle; the other side's rdy = 0.
  - If rd_rdy, go to WAIT_RET.
  - If the owner's req drops before rd_rdy, abort to IDLE; nothing is issued.
- WAIT_RET:
  - Owner's x_ret_valid/x_ret_last/x_ret_data = ret_valid/ret_last/ret_data, combinational.
  - Non-owner ret outputs are 0.
  - On ret_valid && ret_last: go to IDLE; if RR_EN, rr_ptr = the non-owner.
- Requests arriving during ISSUE/WAIT_RET wait; no request is dropped.
- Write hazard tracking:
  - On d_wr_req && d_wr_rdy: wr_pend = 1 and wr_line = d_wr_addr[ADDR_W-1:LINE_OFF_W].
  - On wr_done: wr_pend = 0.
  - Both events in the same cycle: the new write wins, so wr_pend stays 1 with the new line.
- Stray inputs: ret_valid outside WAIT_RET is ignored and is not forwarded; rd_rdy outside ISSUE is ignored.
- Uncached word reads (type 3'b010, single beat with ret_last = 1) take the same path as line reads.
- Reset mid-transfer: the block returns to IDLE with no grant held; downstream is reset together with it.

Decomposition:
- Shared package constants: RD_TYPE_WORD = 3'b010, RD_TYPE_LINE = 3'b100, and the state encodings ST_IDLE, ST_ISSUE, ST_WAIT_RET.
- One natural sub-module, rr_arb2: 2-input arbiter with a priority pointer, purely combinational, exporting grant[1:0]. The FSM, the data steering and the hazard tracker stay in the top module.

Test Plan:
1. i_rd_req, addr 0x1c000040, type 3'b100; rd_rdy after 2 cycles; 4 beats 0xA0..0xA3 -> rd_req rises 1 cycle after i_rd_req; i_rd_rdy pulses with rd_rdy; i_ret_* carry the 4 beats with last on 0xA3; d_ret_valid = 0 throughout.
2. i_rd_req and d_rd_req in the same cycle, RR_EN=1, after reset -> inst served first, then data; repeat both -> data first. With RR_EN=0 -> data always first.
3. d_wr_req && d_wr_rdy at 0x00001230, then d_rd_req at 0x00001238 -> read blocked; wr_done pulse -> grant in the following IDLE cycle. A read at 0x00001240 is not blocked.
4. Grant inst, then i_rd_req drops in ISSUE before rd_rdy -> return to IDLE, no rd_rdy forwarded; a pending d_rd_req is granted next.
5. Single-beat word read from data (type 3'b010) with ret_last on the first beat -> d_ret_last = 1; FSM is in IDLE on the next cycle.
6. resetn = 0 during WAIT_RET after beat 2 -> all outputs 0 next cycle; after release, a new i_rd_req is granted normally and stray ret_valid is not forwarded.
